// File: rtl/dpram_clr.sv
// Dual-port RAM (port A read/write, port B read-only) with a clear sequencer that fills the array.
// Optional macro DPRAM_BYPASS_EN: a port-B read of the address port A writes returns the new data.
module dpram_clr #(
  parameter int          addr_width   = 12,
  parameter int          data_width   = 8,
  parameter int unsigned CLR_VALUE    = 0,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_din,
  output logic [data_width-1:0] a_q,
  input  logic                  a_rd_n,
  input  logic                  a_wr_n,
  input  logic                  a_ce_n,
  input  logic [addr_width-1:0] b_addr,
  output logic [data_width-1:0] b_q,
  input  logic                  b_rd_n,
  input  logic                  b_ce_n
);
  localparam int DEPTH = 1 << addr_width;
  localparam logic [data_width-1:0] CLR_W = data_width'(CLR_VALUE);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic [addr_width-1:0] r_clr_addr, w_clr_addr_nxt;
  logic                  r_busy;
  logic [data_width-1:0] r_a_data, r_b_data;
  logic [data_width-1:0] r_mem [DEPTH];
  logic                  w_we;
  logic [addr_width-1:0] w_waddr;
  logic [data_width-1:0] w_wdata;
  logic                  w_b_fwd;

`ifdef DPRAM_BYPASS_EN
  assign w_b_fwd = ~a_wr_n && (b_addr == a_addr);
`else
  assign w_b_fwd = 1'b0;
`endif

  // Single array write port, shared between port A and the sweep; never written under reset.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_we           = 1'b0;
    w_waddr        = a_addr;
    w_wdata        = a_din;
    case (r_state)
      S_IDLE: begin
        w_we = ~a_wr_n;
        if (clr) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_we           = 1'b1;
        w_waddr        = r_clr_addr;
        w_wdata        = CLR_W;
        w_clr_addr_nxt = r_clr_addr + 1'b1;
        if (&r_clr_addr) w_state_nxt = S_IDLE;
      end
    endcase
    if (reset) w_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLR_ON_RESET ? S_CLEAR : S_IDLE;
      r_busy     <= CLR_ON_RESET;
      r_clr_addr <= '0;
      r_a_data   <= '0;
      r_b_data   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt == S_CLEAR);
      r_clr_addr <= w_clr_addr_nxt;
      // Reads sample the array before this edge's write lands (read-before-write).
      if (r_state == S_IDLE) begin
        if (~a_rd_n) r_a_data <= r_mem[a_addr];
        if (~b_rd_n) r_b_data <= w_b_fwd ? a_din : r_mem[b_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign busy = r_busy;
  assign a_q  = a_ce_n ? '0 : r_a_data;
  assign b_q  = b_ce_n ? '0 : r_b_data;

endmodule

// File: tb/tb_dpram_clr.sv
// Scoreboard bench for dpram_clr: one instance clearing on reset, one coming out idle.
module tb_dpram_clr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clr, a_rd_n, a_wr_n, a_ce_n, b_rd_n, b_ce_n;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_din, a_q, b_q;
  logic       busy;

  logic       clr0, a0_rd_n, a0_wr_n, a0_ce_n, b0_rd_n, b0_ce_n;
  logic [3:0] a0_addr, b0_addr;
  logic [7:0] a0_din, a0_q, b0_q;
  logic       busy0;

  dpram_clr #(.addr_width(4), .data_width(8), .CLR_VALUE(8'hA5), .CLR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy),
    .a_addr(a_addr), .a_din(a_din), .a_q(a_q), .a_rd_n(a_rd_n), .a_wr_n(a_wr_n), .a_ce_n(a_ce_n),
    .b_addr(b_addr), .b_q(b_q), .b_rd_n(b_rd_n), .b_ce_n(b_ce_n));

  dpram_clr #(.addr_width(4), .data_width(8), .CLR_VALUE(8'hA5), .CLR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clr(clr0), .busy(busy0),
    .a_addr(a0_addr), .a_din(a0_din), .a_q(a0_q), .a_rd_n(a0_rd_n), .a_wr_n(a0_wr_n), .a_ce_n(a0_ce_n),
    .b_addr(b0_addr), .b_q(b0_q), .b_rd_n(b0_rd_n), .b_ce_n(b0_ce_n));

  typedef struct { string nm; int port; logic [7:0] v; } exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

`ifdef DPRAM_BYPASS_EN
  localparam logic [7:0] COLL_B = 8'h77;
`else
  localparam logic [7:0] COLL_B = 8'h11;
`endif

  task automatic push(input string nm, input int port, input logic [7:0] v);
    exp_t e;
    e.nm = nm; e.port = port; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      obs = (e.port == 0) ? a_q : (e.port == 1) ? b_q : a0_q;
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", e.nm, obs, e.v);
      end
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr_a(input logic [3:0] ad, input logic [7:0] d);
    a_addr = ad; a_din = d; a_wr_n = 1'b0;
    @(negedge clk);
    a_wr_n = 1'b1;
  endtask

  task automatic rd_a(input logic [3:0] ad, input logic [7:0] v, input string nm);
    a_addr = ad; a_rd_n = 1'b0; a_ce_n = 1'b0;
    push(nm, 0, v);
    @(negedge clk);
    a_rd_n = 1'b1;
    drain();
  endtask

  task automatic rd_b(input logic [3:0] ad, input logic [7:0] v, input string nm);
    b_addr = ad; b_rd_n = 1'b0; b_ce_n = 1'b0;
    push(nm, 1, v);
    @(negedge clk);
    b_rd_n = 1'b1;
    drain();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
    total++; if (a_q !== 8'h00) begin bad++; $display("FAIL rst_a_q got=%h exp=00", a_q); end
    total++; if (b_q !== 8'h00) begin bad++; $display("FAIL rst_b_q got=%h exp=00", b_q); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy0 got=%b exp=0", busy0); end
  endtask

  task automatic test_sweep();
    int n = 0;
    reset = 1'b0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL sweep_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) rd_a(4'(i), 8'hA5, "sweep_fill");
    rd_b(4'd11, 8'hA5, "sweep_fill_b");
  endtask

  task automatic test_rw();
    wr_a(4'd5, 8'h3C);
    rd_a(4'd5, 8'h3C, "rw_a");
    a_ce_n = 1'b1; #1;
    total++; if (a_q !== 8'h00) begin bad++; $display("FAIL rw_ce_gate got=%h exp=00", a_q); end
    a_ce_n = 1'b0; #1;
    total++; if (a_q !== 8'h3C) begin bad++; $display("FAIL rw_ce_ungate got=%h exp=3c", a_q); end
    rd_b(4'd5, 8'h3C, "rw_b");
  endtask

  task automatic test_collision();
    wr_a(4'd9, 8'h11);
    a_addr = 4'd9; a_din = 8'h77; a_wr_n = 1'b0; a_rd_n = 1'b0; a_ce_n = 1'b0;
    b_addr = 4'd9; b_rd_n = 1'b0; b_ce_n = 1'b0;
    push("coll_a", 0, 8'h11);
    push("coll_b", 1, COLL_B);
    @(negedge clk);
    a_wr_n = 1'b1; a_rd_n = 1'b1; b_rd_n = 1'b1;
    drain();
    rd_a(4'd9, 8'h77, "coll_after_a");
    rd_b(4'd9, 8'h77, "coll_after_b");
  endtask

  task automatic test_sweep_block();
    int n;
    wr_a(4'd3, 8'h42);
    rd_a(4'd3, 8'h42, "blk_pre_a");
    rd_b(4'd3, 8'h42, "blk_pre_b");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; n = 1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL blk_busy_rise got=%b exp=1", busy); end
    while (busy === 1'b1 && n < 100) begin
      if (n == 4) begin
        a_addr = 4'd2; a_din = 8'hFF; a_wr_n = 1'b0; a_rd_n = 1'b0;
        b_addr = 4'd2; b_rd_n = 1'b0;
      end else begin
        a_wr_n = 1'b1; a_rd_n = 1'b1; b_rd_n = 1'b1;
      end
      @(negedge clk); n++;
    end
    a_wr_n = 1'b1; a_rd_n = 1'b1; b_rd_n = 1'b1;
    total++; if (n - 1 != 16) begin bad++; $display("FAIL blk_sweep_len got=%0d exp=16", n - 1); end
    total++; if (a_q !== 8'h42) begin bad++; $display("FAIL blk_a_hold got=%h exp=42", a_q); end
    total++; if (b_q !== 8'h42) begin bad++; $display("FAIL blk_b_hold got=%h exp=42", b_q); end
    wr_a(4'd6, 8'h66);
    rd_a(4'd6, 8'h66, "blk_first_idle_wr");
    rd_a(4'd2, 8'hA5, "blk_dropped_wr");
    rd_a(4'd3, 8'hA5, "blk_cleared");
    rd_b(4'd2, 8'hA5, "blk_cleared_b");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    for (int i = 0; i < 16; i++) wr_a(4'(i), 8'h10 + 8'(i));
    rd_a(4'd15, 8'h1F, "mid_pre_a");
    rd_b(4'd14, 8'h1E, "mid_pre_b");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1; a_ce_n = 1'b0; b_ce_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_rst_busy got=%b exp=1", busy); end
    total++; if (a_q !== 8'h00) begin bad++; $display("FAIL mid_rst_a_q got=%h exp=00", a_q); end
    total++; if (b_q !== 8'h00) begin bad++; $display("FAIL mid_rst_b_q got=%h exp=00", b_q); end
    reset = 1'b0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL mid_sweep_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) rd_a(4'(i), 8'hA5, "mid_fill");
    rd_b(4'd15, 8'hA5, "mid_fill_b");
  endtask

  task automatic test_no_clr_on_reset();
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL nc_rst_busy got=%b exp=0", busy0); end
    reset = 1'b0;
    a0_addr = 4'd1; a0_din = 8'h5A; a0_wr_n = 1'b0;
    @(negedge clk);
    a0_wr_n = 1'b1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL nc_idle_busy got=%b exp=0", busy0); end
    a0_addr = 4'd1; a0_rd_n = 1'b0; a0_ce_n = 1'b0;
    push("nc_first_wr", 2, 8'h5A);
    @(negedge clk);
    a0_rd_n = 1'b1;
    drain();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0; n = 1;
    while (busy0 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++; if (n - 1 != 16) begin bad++; $display("FAIL nc_sweep_len got=%0d exp=16", n - 1); end
    a0_addr = 4'd1; a0_rd_n = 1'b0;
    push("nc_cleared", 2, 8'hA5);
    @(negedge clk);
    a0_rd_n = 1'b1;
    drain();
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0;
    a_addr = '0; a_din = '0; a_rd_n = 1'b1; a_wr_n = 1'b1; a_ce_n = 1'b0;
    b_addr = '0; b_rd_n = 1'b1; b_ce_n = 1'b0;
    clr0 = 1'b0; a0_addr = '0; a0_din = '0; a0_rd_n = 1'b1; a0_wr_n = 1'b1; a0_ce_n = 1'b0;
    b0_addr = '0; b0_rd_n = 1'b1; b0_ce_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_rw();
    test_collision();
    test_sweep_block();
    test_reset_mid();
    test_no_clr_on_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpram_clr.md
# dpram_clr

Dual-port synchronous RAM with a CPU read/write port A and a read-only video/scan port B. It adds a hardware clear sequencer that fills the whole array with a fixed value after reset or on request, and an optional write-to-read bypass between ports. It is the parametrised successor to the single-port work RAM used for CPU work RAM, sprite RAM and tile RAM, where the video side must read while the CPU writes.

## Interface
Parameters:
- addr_width, 12: address bits; depth = 2^addr_width words.
- data_width, 8: word width.
- CLR_VALUE, 0: fill value written by the clear sequencer, truncated to data_width.
- CLR_ON_RESET, 1: 1 = start a sweep when reset is released; 0 = come out of reset idle.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- clr, in, 1: one-cycle request to start a clear sweep; honoured only in IDLE.
- busy, out, 1: high while a sweep is running.
- a_addr, in, addr_width: port A address.
- a_din, in, data_width: port A write data.
- a_q, out, data_width: port A read data.
- a_rd_n, in, 1: port A read strobe, active-low.
- a_wr_n, in, 1: port A write strobe, active-low.
- a_ce_n, in, 1: port A output enable, active-low.
- b_addr, in, addr_width: port B address.
- b_q, out, data_width: port B read data.
- b_rd_n, in, 1: port B read strobe, active-low.
- b_ce_n, in, 1: port B output enable, active-low.

## Operation
- Storage: mem[2^addr_width]. Read registers a_data and b_data. a_q = a_ce_n ? 0 : a_data and b_q = b_ce_n ? 0 : b_data (combinational gating).
- FSM states are IDLE and CLEAR, with an addr_width-bit counter clr_addr.
- While reset is high: a_data = 0, b_data = 0, clr_addr = 0, busy = CLR_ON_RESET. State is CLEAR if CLR_ON_RESET, else IDLE. No array writes occur.
- IDLE:
  - ~a_wr_n writes a_din to mem[a_addr].
  - ~a_rd_n loads a_data from mem[a_addr].
  - ~b_rd_n loads b_data from mem[b_addr].
  - clr goes to CLEAR with clr_addr = 0.
- CLEAR:
  - Each cycle writes CLR_VALUE to mem[clr_addr], then clr_addr increments.
  - On the cycle that writes address 2^addr_width−1, the next state is IDLE and clr_addr wraps to 0.
  - Port A writes are dropped. Read strobes on both ports are ignored, so a_data and b_data hold.
  - clr is ignored.
- Same-address access on port A in the same cycle (~a_rd_n and ~a_wr_n): a_data gets the old contents (read-before-write).
- Port B reads the address port A writes in the same cycle: b_data gets the old contents unless the bypass is compiled in (see Configuration).
- Reset mid-sweep: the sweep restarts from address 0 (if CLR_ON_RESET) and partially cleared contents are not relied on.
- Reset never clears the array by itself; only the sweep does.

## Timing
- Read latency is 1 clock. A strobe sampled at edge N makes the data visible on a_q/b_q after edge N.
- Output gating by a_ce_n/b_ce_n is combinational with zero latency.
- A write at edge N is visible to a read strobed at edge N+1.
- Sweep length is exactly 2^addr_width cycles:
  - busy rises on the edge that samples clr, or stays high out of reset.
  - busy falls on the edge after the last-address write.
  - Port A writes are accepted from the first cycle busy is low.
- busy is registered with no combinational path from any input.

## Configuration
- DPRAM_BYPASS_EN defined: in IDLE, if ~b_rd_n and ~a_wr_n with b_addr == a_addr, b_data loads a_din (new data).
- DPRAM_BYPASS_EN undefined: b_data loads the pre-write contents.
- Port A behaviour and sweep behaviour are identical either way.

## Test plan
- Reset-release sweep: addr_width=4, CLR_VALUE=8'hA5, CLR_ON_RESET=1. Release reset, then count cycles → busy high for exactly 16 cycles. After that, port A reads of addresses 0..15 return 8'hA5.
- Read/write basics: write 8'h3C to address 5 via port A. Read it next cycle with a_ce_n=0 → a_q=8'h3C after 1 clock. With a_ce_n=1 → a_q=0. Port B read of address 5 → b_q=8'h3C.
- Collision: in one cycle, port A writes 8'h77 to address 9 (old value 8'h11) while both ports read address 9. Required: a_q=8'h11. b_q=8'h11 without DPRAM_BYPASS_EN, b_q=8'h77 with it.
- Writes blocked during sweep: pulse clr, then attempt a write of 8'hFF to address 2 mid-sweep → after the sweep, address 2 reads CLR_VALUE. Reads held during the sweep leave a_q unchanged.
- Reset mid-sweep: assert reset at clr_addr=7 with CLR_ON_RESET=1 → after release, busy stays high for 16 full cycles, a_q=0 and b_q=0 while reset is held, and all addresses read CLR_VALUE afterwards.
- CLR_ON_RESET=0: after reset → busy=0 immediately. A port A write is accepted on the first cycle after reset. clr issued during IDLE starts a 16-cycle sweep.
